mips_divider: RTL and testbench



---
 rtl/mips_div_pkg.sv | 20 ++
 rtl/mips_divider_sub_step.sv | 24 ++
 rtl/mips_divider.sv | 174 +++++++++++++++++
 tb/tb_mips_divider.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_div_pkg.sv
// Shared types and constants for the multi-cycle MIPS DIV/DIVU unit.
package mips_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = {DIV_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2
  } div_state_e;

  // 1-bit full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/mips_divider_sub_step.sv
// Combinational WIDTH+1-bit trial subtractor (a - b) as a ripple of full-adder cells.
module div_sub_step
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           no_borrow
);

  logic [WIDTH+1:0] carry;

  // a + ~b + 1: carry-in of one completes the two's complement of b.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign {carry[i+1], diff[i]} = full_add(a[i], ~b[i], carry[i]);
  end

  assign no_borrow = carry[WIDTH+1];

endmodule

// File: rtl/mips_divider.sv
// Restoring 32-bit DIV/DIVU unit: one quotient bit per clock, quotient -> LO, remainder -> HI.
// Optional macro DIV_EARLY_OUT_EN skips the iteration loop when |dividend| < |divisor| or divisor == 0.
module mips_divider
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_orig_q, dvd_orig_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_abs_s, b_abs_s;
  logic [WIDTH:0]   shifted_s, sub_diff_s;
  logic             no_borrow_s, take_s;

  assign a_abs_s   = (is_signed && dividend[WIDTH-1]) ? (~dividend + ONE) : dividend;
  assign b_abs_s   = (is_signed && divisor[WIDTH-1])  ? (~divisor + ONE)  : divisor;
  assign shifted_s = {rem_q, quo_q[WIDTH-1]};

  div_sub_step #(.WIDTH(WIDTH)) u_sub (
    .a         (shifted_s),
    .b         ({1'b0, dvs_q}),
    .diff      (sub_diff_s),
    .no_borrow (no_borrow_s)
  );

  // With no borrow the difference is below the divisor, so its top bit is always clear.
  assign take_s = no_borrow_s & ~sub_diff_s[WIDTH];

  // Next-state, datapath and output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    dvd_orig_d  = dvd_orig_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dvs_d      = b_abs_s;
          dvd_orig_d = dividend;
          q_neg_d    = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg_d    = is_signed & dividend[WIDTH-1];
          cnt_d      = {CNT_W{1'b0}};
          busy_d     = 1'b1;
`ifdef DIV_EARLY_OUT_EN
          if ((b_abs_s == ZERO) || (a_abs_s < b_abs_s)) begin
            state_d = FIXUP;
            quo_d   = ZERO;
            rem_d   = a_abs_s;
          end else begin
            state_d = DIVIDE;
            quo_d   = a_abs_s;
            rem_d   = ZERO;
          end
`else
          state_d = DIVIDE;
          quo_d   = a_abs_s;
          rem_d   = ZERO;
`endif
        end else begin
          busy_d = 1'b0;
        end
      end
      DIVIDE: begin
        rem_d = take_s ? sub_diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], take_s};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = FIXUP;
        end else begin
          state_d = DIVIDE;
        end
      end
      FIXUP: begin
        if (dvs_q == ZERO) begin
          quotient_d  = {WIDTH{DIV_ZERO_QUOT[0]}};
          remainder_d = dvd_orig_q;
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = q_neg_q ? (~quo_q + ONE) : quo_q;
          remainder_d = r_neg_q ? (~rem_q + ONE) : rem_q;
          dbz_d       = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = {CNT_W{1'b0}};
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      rem_q       <= ZERO;
      quo_q       <= ZERO;
      dvs_q       <= ZERO;
      dvd_orig_q  <= ZERO;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= ZERO;
      remainder_q <= ZERO;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      dvd_orig_q  <= dvd_orig_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_divider.sv
// Directed scoreboard bench for mips_divider: results, latency, busy window, reset abort.
module tb_mips_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mips_divider dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
    return (s && v[31]) ? (32'd0 - v) : v;
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
`ifdef DIV_EARLY_OUT_EN
    if (b == 32'd0 || mag(a, s) < mag(b, s)) return 1;
`endif
    return 33;
  endfunction

  task automatic push_exp(input logic [31:0] q, input logic [31:0] r, input logic dbz,
                          input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz; e.lat = exp_lat(a, b, s);
    sb.push_back(e);
  endtask

  task automatic model_push(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (s) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b; r = a % b;
    end
    push_exp(q, r, (b == 32'd0), a, b, s);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_q"}, quotient, 32'd0);
    check({tag, "_r"}, remainder, 32'd0);
    check({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int poke_at, input int rst_at);
    int   cycles;
    int   busy_cnt;
    exp_t e;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom_range(0, 1));
    cycles = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && cycles < 60) begin
      if (busy === 1'b1) busy_cnt++;
      if (rst_at > 0 && cycles == rst_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_outputs({tag, "_abort"});
        return;
      end
      if (poke_at > 0 && cycles == poke_at) begin
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_q"}, quotient, e.q);
      check({tag, "_r"}, remainder, e.r);
      check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
      check({tag, "_latency"}, 32'(cycles), 32'(e.lat));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e.lat));
    end
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_q_hold"}, quotient, e.q);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    push_exp(32'd14, 32'd2, 1'b0, 32'd100, 32'd7, 1'b0);
    run_op("u100_7", 32'd100, 32'd7, 1'b0, 0, 0);

    push_exp(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0);

    push_exp(32'hFFFF_FFFD, 32'd1, 1'b0, 32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0, 0);

    push_exp(32'h8000_0000, 32'd0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);

    push_exp(32'hFFFF_FFFF, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0);

    push_exp(32'hFFFF_FFFF, 32'd5, 1'b1, 32'd5, 32'd0, 1'b0);
    run_op("u_5_0", 32'd5, 32'd0, 1'b0, 0, 0);

    push_exp(32'hFFFF_FFFF, 32'd5, 1'b1, 32'd5, 32'd0, 1'b1);
    run_op("s_5_0", 32'd5, 32'd0, 1'b1, 0, 0);

    push_exp(32'd3, 32'd0, 1'b0, 32'd9, 32'd3, 1'b0);
    run_op("u_9_3", 32'd9, 32'd3, 1'b0, 0, 0);

    push_exp(32'd142, 32'd6, 1'b0, 32'd1000, 32'd7, 1'b0);
    run_op("u_poke", 32'd1000, 32'd7, 1'b0, 10, 0);

    run_op("u_reset", 32'd50, 32'd5, 1'b0, 0, 20);

    push_exp(32'd5, 32'd1, 1'b0, 32'd21, 32'd4, 1'b1);
    run_op("s_21_4", 32'd21, 32'd4, 1'b1, 0, 0);

    push_exp(32'd0, 32'd3, 1'b0, 32'd3, 32'd10, 1'b0);
    run_op("u_3_10", 32'd3, 32'd10, 1'b0, 0, 0);

    push_exp(32'd0, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFD, 32'd10, 1'b1);
    run_op("s_m3_10", 32'hFFFF_FFFD, 32'd10, 1'b1, 0, 0);

    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 32'hFFFF_FFFB, 32'd0, 1'b1);
    run_op("s_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 0, 0);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      logic        rs;
      ra = $urandom;
      rb = (i < 3) ? ($urandom >> $urandom_range(0, 28)) : $urandom;
      rs = 1'(i % 2);
      model_push(ra, rb, rs);
      run_op("rand", ra, rb, rs, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
